// File: rtl/mem_main_pkg.sv
// Shared types, default widths and the byte-merge helper for the main memory.
// byte_merge works on MEM_MAX_DATA_W-bit words; callers zero-extend and truncate.
package mem_main_pkg;

  typedef enum logic {MEM_CLEAR, MEM_RUN} mem_state_e;

  localparam int MEM_DATA_W_DEF = 16;
  localparam int MEM_ADDR_W_DEF = 16;
  localparam int MEM_MAX_DATA_W = 512;

  function automatic logic [MEM_MAX_DATA_W-1:0] byte_merge(
    input logic [MEM_MAX_DATA_W-1:0]   old_w,
    input logic [MEM_MAX_DATA_W-1:0]   new_w,
    input logic [MEM_MAX_DATA_W/8-1:0] mask
  );
    logic [MEM_MAX_DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MEM_MAX_DATA_W/8; i++) begin
      if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_main_clr_seq.sv
// Post-reset clear sequencer: walks the array writing zeros, then opens the port.
// Only instantiated when MEM_MAIN_SYNC_CLEAR_EN is defined.
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   MEM_CLEAR | writing 0 to mem[ptr] once per non-halted cycle
//   MEM_RUN   | clear done, ready=1, normal accesses accepted
module mem_main_clr_seq
  import mem_main_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W_DEF,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt_sys,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  // One extra bit so DEPTH = 2**ADDR_W terminates without wrapping.
  localparam int                PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0]  LAST  = PTR_W'(DEPTH - 1);

  mem_state_e        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    if (state_q == MEM_CLEAR && !halt_sys) begin
      clr_we = 1'b1;
      ptr_d  = ptr_q + PTR_W'(1);
      if (ptr_q == LAST) state_d = MEM_RUN;
    end
  end

  assign clr_addr = ptr_q[ADDR_W-1:0];
  assign ready    = (state_q == MEM_RUN);

endmodule

// File: rtl/mem_main_sync.sv
// Single-port word-addressable main memory with byte enables, registered read and range error.
// Define MEM_MAIN_SYNC_CLEAR_EN to zero the array after reset via mem_main_clr_seq.
module mem_main_sync
  import mem_main_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W_DEF,
  parameter int ADDR_W = MEM_ADDR_W_DEF,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                halt_sys,
  input  logic                req,
  input  logic                write_en,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   write_data,
  output logic                ready,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   data_out,
  output logic                err
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready_w;
  logic              acc;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              rd_valid_q, err_q;
  logic [DATA_W-1:0] data_out_q;

  assign acc      = req & ready_w & ~halt_sys;
  assign in_range = ({1'b0, address} < DEPTH_L);
  assign idx      = address[IDX_W-1:0];

`ifdef MEM_MAIN_SYNC_CLEAR_EN
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  mem_main_clr_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .halt_sys (halt_sys),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready_w)
  );

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr[IDX_W-1:0]] <= '0;
    end else if (acc && write_en && in_range) begin
      mem[idx] <= DATA_W'(byte_merge(MEM_MAX_DATA_W'(mem[idx]),
                                     MEM_MAX_DATA_W'(write_data),
                                     (MEM_MAX_DATA_W/8)'(byte_en)));
    end
  end
`else
  // No clear pass: the port opens on the first edge after reset.
  logic ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  assign ready_w = ready_q;

  always_ff @(posedge clk) begin
    if (acc && write_en && in_range) begin
      mem[idx] <= DATA_W'(byte_merge(MEM_MAX_DATA_W'(mem[idx]),
                                     MEM_MAX_DATA_W'(write_data),
                                     (MEM_MAX_DATA_W/8)'(byte_en)));
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= '0;
    end else if (halt_sys) begin
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= acc & ~write_en;
      err_q      <= acc & ~in_range;
      if (acc && !write_en) data_out_q <= in_range ? mem[idx] : '0;
    end
  end

  assign ready    = ready_w;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;
  assign data_out = data_out_q;

endmodule

// File: doc/mem_main_sync.md
# mem_main_sync

Parametrised, single-port, word-addressable main memory that succeeds the fixed 16x64K flop array. It adds:
- configurable data width, address width and depth;
- per-byte write enables;
- a registered read port with a valid strobe;
- an out-of-range error flag;
- a post-reset clear sequencer, replacing the bulk reset of the array.

It sits in the MEM stage of the CPU datapath and honours the system halt.

## Interface
- DATA_W, 16, word width in bits; must be a multiple of 8
- ADDR_W, 16, address width in bits
- DEPTH, 2**ADDR_W, number of implemented words; must be ≤ 2**ADDR_W
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- halt_sys  in  1  system halt; freezes all state while high
- req  in  1  access request, valid for one cycle
- write_en  in  1  1 = write, 0 = read; qualified by req
- byte_en  in  DATA_W/8  per-byte write mask; bit i covers bits [8i+7:8i]
- address  in  ADDR_W  word address
- write_data  in  DATA_W  write data
- ready  out  1  memory is accepting requests
- rd_valid  out  1  data_out holds the result of the read accepted last cycle
- data_out  out  DATA_W  registered read data
- err  out  1  accepted request had address ≥ DEPTH

## Operation
- States are CLEAR and RUN.
  - Reset enters CLEAR with the clear pointer at 0.
  - CLEAR writes 0 to mem[ptr] and increments ptr, once per non-halted cycle.
  - After the write to DEPTH-1, the FSM goes to RUN.
- ready = 1 only in RUN.
- A request is accepted when req & ready & !halt_sys. Requests that are not accepted are dropped, not queued.
- Accepted write to an in-range address: each byte with byte_en[i]=1 is updated at that edge. Other bytes are unchanged. byte_en = 0 is a legal no-op.
- Accepted read to an in-range address: at the next edge, data_out <= mem[address] and rd_valid <= 1.
- Out-of-range address (≥ DEPTH):
  - A write is discarded.
  - A read loads data_out with 0 and sets rd_valid.
  - Either access sets err for one cycle, with the same timing as rd_valid.
- rd_valid and err are single-cycle pulses.
- When no read is accepted, data_out holds its last value.
- Single port: exactly one operation per cycle, so there is no read/write collision case.
- While halt_sys is high:
  - memory, ptr, state and data_out hold;
  - rd_valid and err are 0 from the next edge on.
- rst_n asserted at any time, including mid-clear or mid-read: outputs go to their reset values immediately, and clear restarts from address 0.

## Timing
- Reset values: ready=0, rd_valid=0, data_out=0, err=0, state=CLEAR, ptr=0.
- Read latency is 1 cycle: request at edge N is returned valid after edge N+1. Back-to-back reads give one result per cycle.
- Write takes effect at the accepting edge. A read to the same address in the next cycle returns the new data.
- Clear duration is DEPTH non-halted cycles after rst_n deasserts. ready rises at the edge that performs the final clear write.
- The pointer is ADDR_W+1 bits wide, so DEPTH = 2**ADDR_W terminates without wrap-around.

## Configuration
- MEM_MAIN_SYNC_CLEAR_EN defined: the CLEAR state and pointer exist as described above.
- Not defined:
  - reset goes directly to RUN;
  - ready = 1 from the first clk edge after rst_n deasserts;
  - array contents after reset are undefined (no storage reset);
  - all other behaviour is identical.

## Structure
- Package mem_main_pkg holds:
  - enum mem_state_e {MEM_CLEAR, MEM_RUN};
  - localparam defaults MEM_DATA_W_DEF=16 and MEM_ADDR_W_DEF=16;
  - function byte_merge(old, new, mask).
- One sub-module, mem_main_clr_seq, holds the state register and clear pointer. It outputs clr_we, clr_addr and ready, and is instantiated only under MEM_MAIN_SYNC_CLEAR_EN.
- The array is a DEPTH x DATA_W unpacked memory with no reset, so it is inferable as block RAM.

## Test plan
All scenarios use a bench with DATA_W=16, ADDR_W=5, DEPTH=20.
- Reset then idle: ready is 0 for exactly 20 cycles, then rises. A read of address 7 returns 0x0000 with rd_valid one cycle later.
- Byte-masked write:
  - write 0xABCD to address 3 with byte_en=2'b11, then 0x1234 with byte_en=2'b01;
  - read of address 3 returns 0xAB34.
- Out of range: write 0xFFFF to address 25, then read address 25. err pulses after each access, the read returns 0x0000, and addresses 0–19 are unchanged.
- Halt mid-stream:
  - read address 3 with halt_sys high for 4 cycles;
  - no rd_valid appears during the halt and data_out holds;
  - after release the request is re-issued and returns 0xAB34.
- Halt and reset during clear:
  - halt_sys high for 5 cycles during CLEAR extends the clear to 25 cycles;
  - rst_n pulsed at clear cycle 10 restarts the count, and ready then takes 20 more cycles.
- Clear compiled out (macro undefined): ready is 1 one cycle after reset. Write, then read at address 0 returns the written data.
